sram_axi_bridge: RTL and testbench
==================================

# sram_axi_bridge

Single-outstanding-transaction bridge between the CPU-side cache memory port (the instruction/data cache miss mux in the core top) and the AXI3 master bus. It accepts one read or write request at a time, drives the matching AXI channels, and returns read data or write completion with a one-cycle `mem_ready` pulse. It sits directly downstream of the cache request mux and is the only AXI master in the core.

## Interface

Parameters:
- `AXI_ID`, default 4'b0000: value driven on `arid`, `awid`, `wid`.

Ports:
- `clk` in 1: core clock (`aclk`).
- `rst` in 1: asynchronous, active-high reset.
- `mem_a` in 32: request byte address, passed to AXI unmodified.
- `mem_access` in 1: request valid; held by the requester until `mem_ready`.
- `mem_write` in 1: 1 = write, 0 = read.
- `mem_size` in 2: log2 bytes (0 = byte, 1 = half, 2 = word).
- `mem_sel` in 4: write byte strobes.
- `mem_st_data` in 32: write data.
- `mem_data` out 32: read data; registered, held until the next read completes.
- `mem_ready` out 1: one-cycle completion pulse.
- `flush` in 1: cancel current request (exception in M stage).
- `arid`/`araddr`/`arlen`(8)/`arsize`/`arburst`/`arlock`/`arcache`/`arprot`/`arvalid` out; `arready` in: AR channel.
- `rid`/`rdata`/`rresp`/`rlast`/`rvalid` in; `rready` out: R channel.
- `awid`/`awaddr`/`awlen`(4)/`awsize`/`awburst`/`awlock`/`awcache`/`awprot`/`awvalid` out; `awready` in: AW channel.
- `wid`/`wdata`/`wstrb`/`wlast`/`wvalid` out; `wready` in: W channel.
- `bid`/`bresp`/`bvalid` in; `bready` out: B channel.

## Operation

- Constants: `arlen`/`awlen` = 0, `arburst`/`awburst` = 2'b01, lock/cache/prot = 0, `wlast` = 1.
- States: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
- IDLE: `mem_access` = 1 (and not cancelled) → latch `mem_a`, `mem_size`, `mem_sel`, `mem_st_data`; go to RD_AR if `mem_write` = 0, else WR_AW_W. The AXI address/data/size/strobe outputs come from latched values only.
- RD_AR: `arvalid` = 1, `arsize` = {1'b0, size}; on `arready` → RD_R.
- RD_R: `rready` = 1; on `rvalid` → capture `rdata` into `mem_data`, go to DONE. `rresp`, `rid` and `rlast` are ignored.
- WR_AW_W: `awvalid` and `wvalid` are asserted together. Each drops individually after its own handshake (tracked by the `aw_done`/`w_done` flags). When both are done, including the same cycle → WR_B.
- WR_B: `bready` = 1; on `bvalid` → DONE. `bresp` is ignored.
- DONE: `mem_ready` = 1 for exactly one cycle → IDLE. A request seen during DONE is not sampled; it is sampled in IDLE on the following cycle.
- Once asserted, a valid is never withdrawn before its handshake, including under flush.

## Timing

- Reset (async): state IDLE; all `*valid`/`*ready` outputs 0; `mem_ready` 0; `mem_data` 0; latched registers 0; `aw_done`/`w_done` 0.
- Minimum read latency (`arready` and `rvalid` return at once): access sampled at cycle 0; `arvalid` at cycle 1; R beat at cycle 2; `mem_ready` at cycle 3.
- Minimum write latency: `awvalid`/`wvalid` at cycle 1; `bvalid` accepted at cycle 2; `mem_ready` at cycle 3.
- Back-to-back: a new request can be sampled at the earliest 1 cycle after `mem_ready`.
- Only one AXI transaction is outstanding at a time; R/B beats are not expected outside RD_R/WR_B.

## Configuration

- `SRAM_AXI_BRIDGE_FLUSH_EN` defined:
  - `flush` = 1 in IDLE blocks the start of a new request.
  - `flush` = 1 in any busy state sets a `cancel` flag. The AXI transaction still completes legally, but the final state goes straight to IDLE. `mem_ready` is not pulsed and `mem_data` is not updated.
  - `cancel` clears on entry to IDLE.
- Macro undefined: the `flush` input is ignored; every accepted request completes with `mem_ready`.

## Test plan

- Read, slave zero-wait: `mem_a`=0x1FC0_0000, size 2, `rdata`=0x3C08_BFAF → `araddr`=0x1FC0_0000, `arsize`=3'b010, `arvalid` at cycle 1, `mem_ready` at cycle 3, `mem_data`=0x3C08_BFAF.
- Read with `arready` delayed 3 cycles → `arvalid` held high with a stable address for 4 cycles; exactly one `mem_ready`.
- Byte write with `mem_a`=0xBFAF_8003, `mem_sel`=4'b1000, data 0xAB00_0000:
  - `wready` 2 cycles before `awready` → `wvalid` drops after its own handshake while `awvalid` is held.
  - `wstrb`=4'b1000, `bready` only after both handshakes, `mem_ready` one cycle after `bvalid`.
- Back-to-back: `mem_access` held through a read then a write → second AR/AW issued no earlier than 1 cycle after the first `mem_ready`; no duplicate transaction.
- Flush (macro on):
  - `flush` pulsed during RD_R → the R beat is consumed, `mem_ready` never asserts, `mem_data` unchanged.
  - `flush`=1 in IDLE with `mem_access`=1 → `arvalid` stays 0.
- Async reset asserted in WR_AW_W → all valid/ready outputs 0 immediately (same cycle); state IDLE after release.

Source files
------------

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master bus bundle for sram_axi_bridge.
// master modport: the bridge side; slave modport: interconnect/memory side.
interface sram_axi_bridge_if;
  // AR channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // R channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AW channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // W channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // B channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Single-outstanding-transaction bridge from the cache memory port to AXI3.
// One read or write at a time; completion signalled by a one-cycle mem_ready.
// Optional feature macro: SRAM_AXI_BRIDGE_FLUSH_EN (flush cancels requests;
// the AXI transaction still completes but mem_ready/mem_data are suppressed).
module sram_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'b0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              mem_a,
  input  logic                     mem_access,
  input  logic                     mem_write,
  input  logic [1:0]               mem_size,
  input  logic [3:0]               mem_sel,
  input  logic [31:0]              mem_st_data,
  output logic [31:0]              mem_data,
  output logic                     mem_ready,
  input  logic                     flush,
  sram_axi_bridge_if.master        axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_AR,
    S_RD_R,
    S_WR_AW_W,
    S_WR_B,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        cancel_q, cancel_d;

  logic        flush_w;
  logic        cancel_now;
  logic        aw_fin;
  logic        w_fin;

  logic        arvalid_w;
  logic        rready_w;
  logic        awvalid_w;
  logic        wvalid_w;
  logic        bready_w;
  logic        mem_ready_w;

  // Response attributes carry nothing the core uses.
  logic        unused_resp;
  assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

`ifdef SRAM_AXI_BRIDGE_FLUSH_EN
  assign flush_w = flush;
`else
  logic        unused_flush;
  assign unused_flush = flush;
  assign flush_w      = 1'b0;
`endif

  // A flush in the very cycle the final response arrives still cancels.
  assign cancel_now = cancel_q | flush_w;
  assign aw_fin     = aw_done_q | axi.awready;
  assign w_fin      = w_done_q | axi.wready;

  // State register and request/response holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cancel_q  <= cancel_d;
    end
  end

  // Next-state logic and per-state channel handshake outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    cancel_d    = cancel_q;
    arvalid_w   = 1'b0;
    rready_w    = 1'b0;
    awvalid_w   = 1'b0;
    wvalid_w    = 1'b0;
    bready_w    = 1'b0;
    mem_ready_w = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_access && !flush_w) begin
          addr_d  = mem_a;
          size_d  = mem_size;
          sel_d   = mem_sel;
          wdata_d = mem_st_data;
          state_d = mem_write ? S_WR_AW_W : S_RD_AR;
        end
      end

      S_RD_AR: begin
        arvalid_w = 1'b1;
        if (axi.arready) begin
          state_d = S_RD_R;
        end
      end

      S_RD_R: begin
        rready_w = 1'b1;
        if (axi.rvalid) begin
          if (cancel_now) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = axi.rdata;
            state_d = S_DONE;
          end
        end
      end

      // AW and W are independent; each valid retires on its own handshake
      // and the pair is complete once both flags (or same-cycle readies) hold.
      S_WR_AW_W: begin
        awvalid_w = !aw_done_q;
        wvalid_w  = !w_done_q;
        if (aw_fin && w_fin) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_B;
        end else begin
          aw_done_d = aw_fin;
          w_done_d  = w_fin;
        end
      end

      S_WR_B: begin
        bready_w = 1'b1;
        if (axi.bvalid) begin
          state_d = cancel_now ? S_IDLE : S_DONE;
        end
      end

      S_DONE: begin
        mem_ready_w = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel is sticky while busy and is dropped whenever IDLE is entered.
    if (state_d == S_IDLE) begin
      cancel_d = 1'b0;
    end else if (state_q != S_IDLE && state_q != S_DONE) begin
      cancel_d = cancel_now;
    end
  end

  // Address/data/size/strobe come only from the latched request.
  assign axi.arid    = AXI_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = '0;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arvalid = arvalid_w;

  assign axi.rready  = rready_w;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = '0;
  assign axi.awsize  = {1'b0, size_q};
  assign axi.awburst = 2'b01;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awvalid = awvalid_w;

  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = sel_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_w;

  assign axi.bready  = bready_w;

  assign mem_data    = rdata_q;
  assign mem_ready   = mem_ready_w;

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Randomized self-checking bench for sram_axi_bridge. The reference model is a
// per-transaction timeline computed from the slave wait counts.
module tb_sram_axi_bridge;

  localparam logic [3:0] TB_ID = 4'h5;
`ifdef SRAM_AXI_BRIDGE_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_a = '0;
  logic        mem_access = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  mem_size = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_st_data = '0;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        flush = 1'b0;

  sram_axi_bridge_if axi_bus ();

  sram_axi_bridge #(.AXI_ID(TB_ID)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_a       (mem_a),
    .mem_access  (mem_access),
    .mem_write   (mem_write),
    .mem_size    (mem_size),
    .mem_sel     (mem_sel),
    .mem_st_data (mem_st_data),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .flush       (flush),
    .axi         (axi_bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_data;
  bit          in_done  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check_quiet(input string tag);
    check_eq({tag, " arvalid"}, 32'(axi_bus.arvalid), 32'd0);
    check_eq({tag, " awvalid"}, 32'(axi_bus.awvalid), 32'd0);
    check_eq({tag, " wvalid"},  32'(axi_bus.wvalid),  32'd0);
    check_eq({tag, " rready"},  32'(axi_bus.rready),  32'd0);
    check_eq({tag, " bready"},  32'(axi_bus.bready),  32'd0);
    check_eq({tag, " mem_ready"}, 32'(mem_ready), 32'd0);
  endtask

  task automatic slave_quiet();
    axi_bus.arready = 1'b0;
    axi_bus.awready = 1'b0;
    axi_bus.wready  = 1'b0;
    axi_bus.rvalid  = 1'b0;
    axi_bus.bvalid  = 1'b0;
    axi_bus.rdata   = $urandom;
    axi_bus.rid     = 4'($urandom);
    axi_bus.rresp   = 2'($urandom);
    axi_bus.rlast   = rb();
    axi_bus.bid     = 4'($urandom);
    axi_bus.bresp   = 2'($urandom);
  endtask

  // Called at a negedge; drops the request and checks nothing is issued.
  task automatic idle(input int n);
    mem_access = 1'b0;
    flush      = 1'b0;
    slave_quiet();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_quiet("idle");
    end
    if (n > 0) in_done = 1'b0;
  endtask

  // One request, entered at a negedge. ka/kw/kr: slave wait cycles for
  // AR-or-AW / W / R-or-B. flush_idle: cycles flush is held at request start.
  // flush_at: busy-relative cycle where flush pulses and the request drops.
  task automatic run_txn(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                         input logic [3:0] sel, input logic [31:0] d, input logic [31:0] rd,
                         input int ka, input int kw, input int kr,
                         input int flush_idle, input int flush_at, input bit keep);
    int base, awe, we, dn, rsp, e, start;
    bit canc, e_arv, e_rr, e_awv, e_wv, e_br, e_mr;
    logic [31:0] new_exp;
    base = FLUSH_EN ? flush_idle : 0;
    awe  = base + 1 + ka;
    if (wr) begin
      we  = base + 1 + kw;
      dn  = (awe > we) ? awe : we;
      rsp = dn + 1 + kr;
    end else begin
      we  = 0;
      dn  = 0;
      rsp = awe + 1 + kr;
    end
    e     = rsp + 1;
    canc  = FLUSH_EN && (flush_at >= 1) && (base + flush_at <= e - 1);
    new_exp = (!wr && !canc) ? rd : exp_data;
    start = in_done ? -1 : 0;

    mem_access  = 1'b1;
    mem_write   = wr;
    mem_a       = a;
    mem_size    = sz;
    mem_sel     = sel;
    mem_st_data = d;

    for (int c = start; c <= e; c++) begin
      if (c >= 0) begin
        e_arv = !wr && (c >= base + 1) && (c <= awe);
        e_rr  = !wr && (c >= awe + 1) && (c <= rsp);
        e_awv = wr && (c >= base + 1) && (c <= awe);
        e_wv  = wr && (c >= base + 1) && (c <= we);
        e_br  = wr && (c >= dn + 1) && (c <= rsp);
        e_mr  = (c == e) && !canc;
        check_eq("arvalid",   32'(axi_bus.arvalid), 32'(e_arv));
        check_eq("rready",    32'(axi_bus.rready),  32'(e_rr));
        check_eq("awvalid",   32'(axi_bus.awvalid), 32'(e_awv));
        check_eq("wvalid",    32'(axi_bus.wvalid),  32'(e_wv));
        check_eq("bready",    32'(axi_bus.bready),  32'(e_br));
        check_eq("mem_ready", 32'(mem_ready),       32'(e_mr));
        if (e_arv) begin
          check_eq("araddr", axi_bus.araddr, a);
          check_eq("arsize", 32'(axi_bus.arsize), 32'({1'b0, sz}));
        end
        if (e_awv) begin
          check_eq("awaddr", axi_bus.awaddr, a);
          check_eq("awsize", 32'(axi_bus.awsize), 32'({1'b0, sz}));
        end
        if (e_wv) begin
          check_eq("wdata", axi_bus.wdata, d);
          check_eq("wstrb", 32'(axi_bus.wstrb), 32'(sel));
          check_eq("wlast", 32'(axi_bus.wlast), 32'd1);
        end
        if (c == e) check_eq("mem_data", mem_data, new_exp);

        flush = (c < flush_idle) || ((flush_at >= 1) && (c == base + flush_at));
        if (((flush_at >= 1) && (c >= base + flush_at)) || ((c == e) && !keep))
          mem_access = 1'b0;
        slave_quiet();
        if (wr) begin
          axi_bus.arready = rb();
          axi_bus.awready = (c == awe) ? 1'b1 : ((c >= base + 1) && (c < awe)) ? 1'b0 : rb();
          axi_bus.wready  = (c == we)  ? 1'b1 : ((c >= base + 1) && (c < we))  ? 1'b0 : rb();
          axi_bus.bvalid  = (c == rsp);
        end else begin
          axi_bus.awready = rb();
          axi_bus.wready  = rb();
          axi_bus.arready = (c == awe) ? 1'b1 : ((c >= base + 1) && (c < awe)) ? 1'b0 : rb();
          axi_bus.rvalid  = (c == rsp);
          if (c == rsp) axi_bus.rdata = rd;
        end
      end
      if (c < e) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    exp_data = new_exp;
    in_done  = !canc;
  endtask

  initial begin
    slave_quiet();
    #1 rst = 1'b1;
    #2;
    check_quiet("async reset");
    repeat (2) @(negedge clk);
    check_eq("reset mem_data", mem_data, 32'd0);
    check_eq("reset araddr", axi_bus.araddr, 32'd0);
    check_eq("reset wstrb", 32'(axi_bus.wstrb), 32'd0);
    check_eq("arlen", 32'(axi_bus.arlen), 32'd0);
    check_eq("awlen", 32'(axi_bus.awlen), 32'd0);
    check_eq("arburst", 32'(axi_bus.arburst), 32'd1);
    check_eq("awburst", 32'(axi_bus.awburst), 32'd1);
    check_eq("arid", 32'(axi_bus.arid), 32'(TB_ID));
    check_eq("awid", 32'(axi_bus.awid), 32'(TB_ID));
    check_eq("wid", 32'(axi_bus.wid), 32'(TB_ID));
    check_eq("attr", 32'({axi_bus.arlock, axi_bus.arcache, axi_bus.arprot,
                          axi_bus.awlock, axi_bus.awcache, axi_bus.awprot}), 32'd0);
    rst = 1'b0;
    exp_data = '0;
    idle(2);

    // Zero-wait boot read.
    run_txn(1'b0, 32'h1FC0_0000, 2'd2, 4'hF, 32'h0, 32'h3C08_BFAF, 0, 0, 0, 0, 0, 1'b0);
    idle(1);
    // Read with AR accepted late.
    run_txn(1'b0, 32'h0000_1234, 2'd2, 4'hF, 32'h0, $urandom, 3, 0, 1, 0, 0, 1'b0);
    idle(1);
    // Byte write, W accepted two cycles before AW.
    run_txn(1'b1, 32'hBFAF_8003, 2'd0, 4'b1000, 32'hAB00_0000, 32'h0, 2, 0, 1, 0, 0, 1'b0);
    idle(1);
    // Back-to-back read then write with the request held throughout.
    run_txn(1'b0, 32'h8000_0040, 2'd2, 4'hF, 32'h0, $urandom, 0, 0, 0, 0, 0, 1'b1);
    run_txn(1'b1, 32'h8000_0044, 2'd1, 4'b0011, 32'h0000_BEEF, 32'h0, 0, 1, 0, 0, 0, 1'b1);
    idle(2);
    // Flush pulsed while waiting for R.
    run_txn(1'b0, 32'h0000_2000, 2'd2, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 0, 2, 0, 2, 1'b0);
    idle(1);
    // Flush held in IDLE with a pending request.
    run_txn(1'b0, 32'h0000_3000, 2'd1, 4'hF, 32'h0, $urandom, 0, 0, 0, 3, 0, 1'b0);
    idle(1);

    // Async reset while in WR_AW_W.
    mem_access = 1'b1;
    mem_write  = 1'b1;
    mem_a      = 32'hCAFE_0000;
    mem_sel    = 4'hF;
    slave_quiet();
    @(posedge clk);
    @(negedge clk);
    check_eq("pre-reset awvalid", 32'(axi_bus.awvalid), 32'd1);
    check_eq("pre-reset wvalid", 32'(axi_bus.wvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_quiet("mid-write reset");
    check_eq("mid-write reset mem_data", mem_data, 32'd0);
    mem_access = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_data = '0;
    in_done  = 1'b0;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      bit wr, keep;
      int fi, fa;
      wr   = rb();
      keep = rb();
      fi   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      fa   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      run_txn(wr, $urandom, 2'($urandom_range(0, 3)), 4'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              fi, fa, keep);
      if (!keep || fa != 0) idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
